// File: rtl/debounce_3ch.sv
// Three-channel switch debouncer: each raw input is synchronized, then must hold
// a new level for CNT_MAX consecutive cycles before its debounced output follows.

module debounce_ch #(
    parameter int CNT_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic out,
    output logic chg
);
    localparam int CW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(CNT_MAX - 1);

    typedef enum logic [1:0] {STABLE0, WAIT1, STABLE1, WAIT0} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    sync_ff;
    logic          sync, out_nxt;

    assign sync    = sync_ff[1];
    assign out     = (state == STABLE1) || (state == WAIT0);
    assign out_nxt = (state_nxt == STABLE1) || (state_nxt == WAIT0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= 2'b00;
            state   <= STABLE0;
            cnt     <= '0;
            chg     <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], raw};
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            chg     <= out_nxt ^ out;
        end
    end

    // WAITx holds the candidate level; any reversal drops back to the old level.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            STABLE0: if (sync) begin
                state_nxt = WAIT1;
                cnt_nxt   = CW'(1);
            end
            WAIT1: if (!sync) begin
                state_nxt = STABLE0;
            end else if (cnt == LAST) begin
                state_nxt = STABLE1;
            end else begin
                cnt_nxt   = cnt + CW'(1);
            end
            STABLE1: if (!sync) begin
                state_nxt = WAIT0;
                cnt_nxt   = CW'(1);
            end
            WAIT0: if (sync) begin
                state_nxt = STABLE1;
            end else if (cnt == LAST) begin
                state_nxt = STABLE0;
            end else begin
                cnt_nxt   = cnt + CW'(1);
            end
            default: state_nxt = STABLE0;
        endcase
    end
endmodule

module debounce_3ch #(
    parameter int CNT_MAX = 4
) (
    input  logic       in_CLK,
    input  logic       in_RST_N,
    input  logic       in_A,
    input  logic       in_B,
    input  logic       in_C,
    output logic       out_A,
    output logic       out_B,
    output logic       out_C,
    output logic [2:0] out_CHG
);
    localparam int NUM_LANES = 3;

    logic [NUM_LANES-1:0] raw, deb;

    assign raw = {in_C, in_B, in_A};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        debounce_ch #(.CNT_MAX(CNT_MAX)) u_ch (
            .clk  (in_CLK),
            .rst_n(in_RST_N),
            .raw  (raw[i]),
            .out  (deb[i]),
            .chg  (out_CHG[i])
        );
    end

    assign out_A = deb[0];
    assign out_B = deb[1];
    assign out_C = deb[2];
endmodule

// File: tb/tb_debounce_3ch.sv
// Directed bench for debounce_3ch (CNT_MAX=4): latency, bounce and glitch
// rejection, simultaneous channels, and asynchronous reset behaviour.

module tb_debounce_3ch;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       a, b, c;
    logic       oa, ob, oc;
    logic [2:0] chg;
    int         total = 0;
    int         fails = 0;

    debounce_3ch #(.CNT_MAX(4)) dut (
        .in_CLK  (clk),
        .in_RST_N(rst_n),
        .in_A    (a),
        .in_B    (b),
        .in_C    (c),
        .out_A   (oa),
        .out_B   (ob),
        .out_C   (oc),
        .out_CHG (chg)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
        #2;
        check("reset_outs", {oc, ob, oa}, 3'b000);
        check("reset_chg", chg, 3'b000);
        tick(2);
        #2 rst_n = 1'b1;
        tick(2);
        check("idle_outs", {oc, ob, oa}, 3'b000);

        // clean rise on A: out_A at edge 6, one-cycle strobe
        a = 1'b1;
        tick(5);
        check("rise_a_e5", {oc, ob, oa}, 3'b000);
        check("rise_a_e5_chg", chg, 3'b000);
        tick(1);
        check("rise_a_e6", {oc, ob, oa}, 3'b001);
        check("rise_a_e6_chg", chg, 3'b001);
        tick(1);
        check("rise_a_e7_chg", chg, 3'b000);
        check("rise_a_e7", {oc, ob, oa}, 3'b001);

        // bounce on B: 1,0,1,0 then held 1
        for (int i = 0; i < 4; i++) begin
            b = (i % 2 == 0);
            tick(1);
            check("bounce_b_out", {2'b00, ob}, 3'b000);
            check("bounce_b_chg", chg, 3'b000);
        end
        b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("bounce_b_wait", {2'b00, ob}, 3'b000);
        end
        tick(1);
        check("bounce_b_e6", {oc, ob, oa}, 3'b011);
        check("bounce_b_e6_chg", chg, 3'b010);

        // 3-cycle glitch on C must be rejected
        c = 1'b1;
        tick(3);
        c = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("glitch_c_out", {2'b00, oc}, 3'b000);
            check("glitch_c_chg", {2'b00, chg[2]}, 3'b000);
            tick(1);
        end

        // back to all-low
        a = 1'b0; b = 1'b0;
        tick(5);
        check("fall_ab_e5", {oc, ob, oa}, 3'b011);
        tick(1);
        check("fall_ab_e6", {oc, ob, oa}, 3'b000);
        check("fall_ab_e6_chg", chg, 3'b011);
        tick(2);

        // simultaneous rise, then B falls alone
        a = 1'b1; b = 1'b1; c = 1'b1;
        tick(5);
        check("sim_e5", {oc, ob, oa}, 3'b000);
        tick(1);
        check("sim_e6", {oc, ob, oa}, 3'b111);
        check("sim_e6_chg", chg, 3'b111);
        tick(1);
        check("sim_e7_chg", chg, 3'b000);
        b = 1'b0;
        tick(5);
        check("b_fall_e5", {oc, ob, oa}, 3'b111);
        tick(1);
        check("b_fall_e6", {oc, ob, oa}, 3'b101);
        check("b_fall_e6_chg", chg, 3'b010);
        tick(1);
        check("b_fall_e7_chg", chg, 3'b000);

        // asynchronous reset between edges while out_A=1
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outs", {oc, ob, oa}, 3'b000);
        check("async_rst_chg", chg, 3'b000);
        a = 1'b0; b = 1'b0; c = 1'b0;
        tick(2);
        #2 rst_n = 1'b1;
        tick(8);
        check("quiet_after_rst", {oc, ob, oa}, 3'b000);

        // mid-qualification reset on A
        a = 1'b1;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        check("midrst_out", {oc, ob, oa}, 3'b000);
        check("midrst_chg", chg, 3'b000);
        #2 rst_n = 1'b1;
        tick(5);
        check("midrst_e5", {oc, ob, oa}, 3'b000);
        tick(1);
        check("midrst_e6", {oc, ob, oa}, 3'b001);
        check("midrst_e6_chg", chg, 3'b001);
        tick(1);
        check("midrst_e7_chg", chg, 3'b000);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/debounce_3ch.md
DEBOUNCE_3CH -- requirements
Module: debounce_3ch

Interface
REQ-001 Parameter CNT_MAX, default 4: consecutive stable cycles required before a debounced output changes; legal range 2..65535.
REQ-002 in_CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 in_RST_N  input  1  reset, asynchronous assert, active-low.
REQ-004 in_A  input  1  raw asynchronous channel A (switch/sensor), may bounce.
REQ-005 in_B  input  1  raw asynchronous channel B.
REQ-006 in_C  input  1  raw asynchronous channel C.
REQ-007 out_A  output  1  debounced channel A, registered; feeds the downstream 3-input AND gate.
REQ-008 out_B  output  1  debounced channel B, registered.
REQ-009 out_C  output  1  debounced channel C, registered.
REQ-010 out_CHG  output  3  one-cycle change strobes, bit0=A, bit1=B, bit2=C, registered.

Function
REQ-011 Three identical independent channels; no channel affects another's timing or state.
REQ-012 Each channel has a 2-flop synchronizer; the synchronized value (sync) lags the raw input by 2 rising edges.
REQ-013 Each channel has a 4-state FSM: STABLE0, WAIT1, STABLE1, WAIT0; out_x = 1 in STABLE1 and WAIT0, 0 otherwise.
REQ-014 Each channel has a counter of width ceil(log2(CNT_MAX)); it never exceeds CNT_MAX-1 and never wraps.
REQ-015 STABLE0: sync=1 -> WAIT1 with counter=1; sync=0 -> stay, counter=0.
REQ-016 WAIT1: sync=0 -> STABLE0, counter=0 (bounce rejected); sync=1 and counter<CNT_MAX-1 -> counter+1; sync=1 and counter=CNT_MAX-1 -> STABLE1, counter=0, out_x becomes 1.
REQ-017 STABLE1/WAIT0 are the mirror of REQ-015/016 with sync polarity inverted; the exit from WAIT0 to STABLE0 drives out_x to 0.
REQ-018 Latency: raw input changes before edge 1 and stays constant -> out_x changes at edge 2+CNT_MAX (edge 6 for default).
REQ-019 Any single-cycle reversal of sync during WAITx restarts the qualification; the output does not change.
REQ-020 out_CHG[x] is 1 for exactly the cycle following the edge on which out_x changes, and 0 otherwise; simultaneous changes on several channels assert several bits together.
REQ-021 A pulse on the raw input shorter than CNT_MAX cycles (after synchronization) produces no output change and no strobe.
REQ-022 The outputs have no combinational path from any input.

Reset
REQ-023 While in_RST_N=0: all synchronizer flops 0, all counters 0, all FSMs STABLE0, out_A/out_B/out_C=0, out_CHG=3'b000, applied immediately without waiting for a clock edge.
REQ-024 Reset asserted mid-qualification (WAITx) abandons it; after release, the channel re-qualifies from STABLE0 with a fresh count.
REQ-025 After release, raw inputs held at 1 produce out_x=1 at edge 2+CNT_MAX counted from the first rising edge after release, with out_CHG[x] pulsing once.

Verification
REQ-026 Reset check: assert in_RST_N=0 between clock edges with out_A=1 -> out_A=0 and out_CHG=000 immediately.
REQ-027 Clean rise: CNT_MAX=4, in_A 0->1 held -> out_A=1 at edge 6, out_CHG=001 for one cycle, out_B/out_C stay 0.
REQ-028 Bounce: in_B toggles 1,0,1,0 on successive cycles, then held at 1 -> no change during toggling; out_B=1 exactly 6 edges after the final rise.
REQ-029 Glitch rejection: 3-cycle high pulse on in_C with CNT_MAX=4 -> out_C stays 0, out_CHG[2] never asserted.
REQ-030 Simultaneous: in_A,in_B,in_C rise on the same cycle -> all outputs rise on the same edge, out_CHG=111 for one cycle; then in_B falls -> out_B=0 six edges later, out_CHG=010.
REQ-031 Mid-count reset: in_A rises, reset pulsed at edge 4, in_A held at 1 -> out_A=0 through reset, rises at edge 6 after release.
